// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle between the instruction source / external ALU and alu_issue_ctrl.
// slave is the controller's view; master is the source/ALU/debug side.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CTRL_W = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        instr_kind;
    logic [CTRL_W-1:0] instr_ctrl;
    logic [ADDR_W-1:0] instr_dst;
    logic [ADDR_W-1:0] instr_src_a;
    logic [ADDR_W-1:0] instr_src_b;
    logic [DATA_W-1:0] instr_imm;
    logic [DATA_W-1:0] alu_ain;
    logic [DATA_W-1:0] alu_bin;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_aluout;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport slave (
        input  instr_valid, instr_kind, instr_ctrl, instr_dst,
               instr_src_a, instr_src_b, instr_imm, alu_aluout, rd_addr,
        output instr_ready, alu_ain, alu_bin, alu_ctrl, done, result, rd_data
    );

    modport master (
        output instr_valid, instr_kind, instr_ctrl, instr_dst,
               instr_src_a, instr_src_b, instr_imm, alu_aluout, rd_addr,
        input  instr_ready, alu_ain, alu_bin, alu_ctrl, done, result, rd_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the external 8-bit ALU: register file, one instruction in
// flight, operand drive, result capture and write-back.
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3,
    parameter int CTRL_W = 4
) (
    input logic            clk,
    input logic            reset,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OPER, CAPT} state_t;

    localparam logic [1:0] KIND_ALU   = 2'd1;
    localparam logic [1:0] KIND_LOADI = 2'd2;

    state_t            state_q;
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] ain_q;
    logic [DATA_W-1:0] bin_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] result_q;
    logic              done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            dst_q    <= '0;
            hold_q   <= '0;
            ain_q    <= '0;
            bin_q    <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.instr_valid) begin
                        // Operands are read here, before any write-back, so
                        // src==dst needs no forwarding.
                        case (bus.instr_kind)
                            KIND_ALU: begin
                                ain_q   <= rf_q[bus.instr_src_a];
                                bin_q   <= rf_q[bus.instr_src_b];
                                ctrl_q  <= bus.instr_ctrl;
                                dst_q   <= bus.instr_dst;
                                state_q <= OPER;
                            end
                            KIND_LOADI: begin
                                hold_q  <= bus.instr_imm;
                                dst_q   <= bus.instr_dst;
                                state_q <= CAPT;
                            end
                            default: ;
                        endcase
                    end
                end
                OPER: begin
                    // ALU has had a full cycle to settle on the registered operands.
                    hold_q  <= bus.alu_aluout;
                    state_q <= CAPT;
                end
                CAPT: begin
                    rf_q[dst_q] <= hold_q;
                    result_q    <= hold_q;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.alu_ain     = ain_q;
    assign bus.alu_bin     = bin_q;
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.rd_data     = rf_q[bus.rd_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: ALU stub, shadow register model and
// a queue of expected retire values checked on every done pulse.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();
    alu_issue_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    bit stub_add = 1'b0;
    assign bus.alu_aluout = stub_add ? (bus.alu_ain + bus.alu_bin) : (bus.alu_ain ^ bus.alu_bin);

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    logic [7:0] model [8];
    logic [7:0] exp_q [$];
    int done_cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Retire monitor: every done pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            done_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done result=%h with no pending instruction", bus.result);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.result !== e) begin
                    errors++;
                    $display("FAIL retire_result got=%h exp=%h", bus.result, e);
                end
            end
        end
    end

    function automatic logic [7:0] stub_model(input logic [7:0] a, input logic [7:0] b);
        return stub_add ? a + b : a ^ b;
    endfunction

    task automatic set_fields(input logic [1:0] kind, input logic [3:0] ctrl, input logic [2:0] dst,
                              input logic [2:0] a, input logic [2:0] b, input logic [7:0] imm);
        bus.instr_kind  = kind;
        bus.instr_ctrl  = ctrl;
        bus.instr_dst   = dst;
        bus.instr_src_a = a;
        bus.instr_src_b = b;
        bus.instr_imm   = imm;
    endtask

    task automatic push_expect(input bit push);
        logic [7:0] v;
        if (!push) return;
        if (bus.instr_kind == 2'd2) v = bus.instr_imm;
        else v = stub_model(model[bus.instr_src_a], model[bus.instr_src_b]);
        model[bus.instr_dst] = v;
        exp_q.push_back(v);
    endtask

    task automatic send(input logic [1:0] kind, input logic [3:0] ctrl, input logic [2:0] dst,
                        input logic [2:0] a, input logic [2:0] b, input logic [7:0] imm,
                        input bit push, output int acc);
        int n;
        @(negedge clk);
        set_fields(kind, ctrl, dst, a, b, imm);
        bus.instr_valid = 1'b1;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout instr_ready=%b after %0d cycles", bus.instr_ready, n);
            bus.instr_valid = 1'b0;
            acc = -1;
            return;
        end
        push_expect(push);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, output int dcyc, output bit ok);
        int n;
        n = 0;
        while (done_cnt == base && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (done_cnt > base);
        dcyc = last_done_cyc;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl ready=%b done=%b exp ready=1 done=0", bus.instr_ready, bus.done);
        end
        checks++;
        if (bus.alu_ain !== 8'h00 || bus.alu_bin !== 8'h00 || bus.alu_ctrl !== 4'h0 || bus.result !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs ain=%h bin=%h ctrl=%h result=%h exp all 0",
                     bus.alu_ain, bus.alu_bin, bus.alu_ctrl, bus.result);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rd_addr = i[2:0];
            #1;
            checks++;
            if (bus.rd_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_rf r%0d got=%h exp=00", i, bus.rd_data);
            end
        end
    endtask

    task automatic retire_check(input string name, input int acc, input int lat,
                                input logic [2:0] dst, input int base);
        int dcyc;
        bit ok;
        wait_done(base, dcyc, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done_timeout done_cnt=%0d exp>%0d", name, done_cnt, base);
        end else if (dcyc - acc !== lat) begin
            errors++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, dcyc - acc, lat);
        end
        bus.rd_addr = dst;
        #1;
        checks++;
        if (bus.rd_data !== model[dst]) begin
            errors++;
            $display("FAIL %s_rf r%0d got=%h exp=%h", name, dst, bus.rd_data, model[dst]);
        end
    endtask

    task automatic test_loadi;
        int acc;
        int base;
        base = done_cnt;
        send(2'd2, 4'h0, 3'd1, 3'd0, 3'd0, 8'hA5, 1'b1, acc);
        retire_check("loadi_r1", acc, 1, 3'd1, base);
        base = done_cnt;
        send(2'd2, 4'h0, 3'd2, 3'd0, 3'd0, 8'h3C, 1'b1, acc);
        retire_check("loadi_r2", acc, 1, 3'd2, base);
    endtask

    task automatic test_alu_xor;
        int acc;
        int base;
        stub_add = 1'b0;
        base = done_cnt;
        send(2'd1, 4'h6, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, acc);
        checks++;
        if (bus.alu_ain !== 8'hA5 || bus.alu_bin !== 8'h3C || bus.alu_ctrl !== 4'h6) begin
            errors++;
            $display("FAIL alu_operands ain=%h bin=%h ctrl=%h exp A5 3C 6",
                     bus.alu_ain, bus.alu_bin, bus.alu_ctrl);
        end
        retire_check("alu_xor", acc, 2, 3'd3, base);
        checks++;
        if (bus.result !== 8'h99) begin
            errors++;
            $display("FAIL alu_xor_result got=%h exp=99", bus.result);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        int nr [3];
        int n;
        logic [2:0] dsts [3];
        logic [2:0] as [3];
        logic [2:0] bs [3];
        dsts = '{3'd5, 3'd6, 3'd7};
        as   = '{3'd1, 3'd5, 3'd6};
        bs   = '{3'd2, 3'd1, 3'd3};
        stub_add = 1'b0;
        base = done_cnt;
        done_cyc_q.delete();
        @(negedge clk);
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_fields(2'd1, 4'h6, dsts[k], as[k], bs[k], 8'h00);
            nr[k] = 0;
            n = 0;
            if (k > 0) @(negedge clk);
            while (bus.instr_ready !== 1'b1 && n < 20) begin
                nr[k]++;
                n++;
                @(negedge clk);
            end
            push_expect(1'b1);
            @(posedge clk);
            #1;
        end
        bus.instr_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (nr[k] !== 2) begin
                errors++;
                $display("FAIL b2b_ready_low instr%0d not-ready cycles=%0d exp=2", k, nr[k]);
            end
        end
        n = 0;
        while (done_cnt < base + 3 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - base !== 3) begin
            errors++;
            $display("FAIL b2b_done_count got=%0d exp=3", done_cnt - base);
        end else begin
            checks++;
            if (done_cyc_q[1] - done_cyc_q[0] !== 3 || done_cyc_q[2] - done_cyc_q[1] !== 3) begin
                errors++;
                $display("FAIL b2b_spacing gaps=%0d,%0d exp=3,3",
                         done_cyc_q[1] - done_cyc_q[0], done_cyc_q[2] - done_cyc_q[1]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            bus.rd_addr = dsts[k];
            #1;
            checks++;
            if (bus.rd_data !== model[dsts[k]]) begin
                errors++;
                $display("FAIL b2b_rf r%0d got=%h exp=%h", dsts[k], bus.rd_data, model[dsts[k]]);
            end
        end
    endtask

    task automatic test_alias;
        int acc;
        int base;
        stub_add = 1'b1;
        base = done_cnt;
        send(2'd2, 4'h0, 3'd4, 3'd0, 3'd0, 8'h0F, 1'b1, acc);
        retire_check("alias_load", acc, 1, 3'd4, base);
        for (int k = 0; k < 2; k++) begin
            base = done_cnt;
            send(2'd1, 4'h2, 3'd4, 3'd4, 3'd4, 8'h00, 1'b1, acc);
            retire_check("alias_op", acc, 2, 3'd4, base);
            checks++;
            if (bus.result !== (k == 0 ? 8'h1E : 8'h3C)) begin
                errors++;
                $display("FAIL alias_result%0d got=%h exp=%h", k, bus.result, (k == 0 ? 8'h1E : 8'h3C));
            end
        end
    endtask

    task automatic test_nop;
        int acc;
        int base;
        base = done_cnt;
        send(2'd0, 4'h5, 3'd1, 3'd2, 3'd3, 8'hFF, 1'b0, acc);
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL nop_ready got=%b exp=1", bus.instr_ready);
        end
        send(2'd3, 4'h5, 3'd2, 3'd1, 3'd3, 8'hEE, 1'b0, acc);
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL kind3_ready got=%b exp=1", bus.instr_ready);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt !== base) begin
            errors++;
            $display("FAIL nop_done pulses=%0d exp=0", done_cnt - base);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rd_addr = i[2:0];
            #1;
            checks++;
            if (bus.rd_data !== model[i]) begin
                errors++;
                $display("FAIL nop_rf r%0d got=%h exp=%h", i, bus.rd_data, model[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int acc;
        int base;
        stub_add = 1'b0;
        base = done_cnt;
        send(2'd1, 4'h9, 3'd5, 3'd1, 3'd2, 8'h00, 1'b0, acc);
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt !== base) begin
            errors++;
            $display("FAIL mid_reset_done pulses=%0d exp=0", done_cnt - base);
        end
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.alu_ain !== 8'h00 || bus.alu_bin !== 8'h00 || bus.alu_ctrl !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset_state ready=%b ain=%h bin=%h ctrl=%h exp 1 00 00 0",
                     bus.instr_ready, bus.alu_ain, bus.alu_bin, bus.alu_ctrl);
        end
        bus.rd_addr = 3'd5;
        #1;
        checks++;
        if (bus.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_r5 got=%h exp=00", bus.rd_data);
        end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.rd_addr = 3'd0;
        set_fields(2'd0, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        test_reset();
        test_loadi();
        test_alu_xor();
        test_back_to_back();
        test_alias();
        test_nop();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_retires left=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 8-bit ALU: holds an 8-entry operand register file, accepts instructions over a valid/ready handshake, and drives the ALU's operand and control inputs (ain, bin, ctrl).
- Captures the ALU's combinational result (aluout) and writes it back to the destination register.
- Sits between the instruction source (bench or future fetch/MEM stage) and the ALU; the ALU itself is external.

Parameters:
- DATA_W, 8, operand/result width; matches ALU ain/bin/aluout
- NREGS, 8, number of registers in the file
- ADDR_W, 3, register address width; log2(NREGS)
- CTRL_W, 4, ALU control width; matches ALU ctrl

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction present on instr_* inputs
- instr_ready  output  1  block can accept an instruction this cycle
- instr_kind  input  2  0=NOP, 1=ALU, 2=LOADI, 3=reserved (treated as NOP)
- instr_ctrl  input  CTRL_W  ALU control code, passed through unmodified
- instr_dst  input  ADDR_W  destination register
- instr_src_a  input  ADDR_W  operand A register
- instr_src_b  input  ADDR_W  operand B register
- instr_imm  input  DATA_W  immediate for LOADI
- alu_ain  output  DATA_W  registered operand A to ALU
- alu_bin  output  DATA_W  registered operand B to ALU
- alu_ctrl  output  CTRL_W  registered control to ALU
- alu_aluout  input  DATA_W  ALU result; combinational from alu_ain/alu_bin/alu_ctrl
- done  output  1  one-cycle pulse when an instruction retires
- result  output  DATA_W  value written at retire; holds until next retire
- rd_addr  input  ADDR_W  debug read address
- rd_data  output  DATA_W  combinational read of rf[rd_addr]; reflects writes from the following cycle onward

Behaviour:
- FSM states: IDLE, OPER, CAPT.
- Reset (asynchronous, any state):
  - Forces IDLE.
  - Clears all registers, alu_ain, alu_bin, alu_ctrl, result and done to 0.
  - instr_ready=1 after reset deasserts.
  - An instruction in flight is discarded with no write.
- instr_ready = (state==IDLE). An instruction is accepted on a clock edge where instr_valid && instr_ready.
- ALU instruction, accepted at edge T:
  - Edge T: alu_ain<=rf[src_a], alu_bin<=rf[src_b], alu_ctrl<=instr_ctrl; state<=OPER. dst is latched internally.
  - OPER lasts one full cycle so the ALU output settles.
  - Edge T+1: state<=CAPT, and alu_aluout is sampled into a holding register.
  - Edge T+2: rf[dst]<=held value, result<=held value, done=1 for the CAPT cycle only, state<=IDLE.
  - Issue-to-done latency is 2 cycles. Throughput is 1 instruction per 3 cycles.
- LOADI accepted at T:
  - Held value<=instr_imm; state<=CAPT (skips OPER).
  - Retires at edge T+1 exactly as above; alu_* outputs unchanged.
- NOP/reserved accepted at T: no state change, stays IDLE, no done, no write.
- Source equals destination (e.g. r3<=r3 op r3): operands are read at accept, before the write. No forwarding is needed because only one instruction is in flight.
- alu_ain, alu_bin and alu_ctrl hold their values after retire until the next ALU accept.
- instr_valid while not ready is ignored. The source must hold the instruction; the block does not latch it.
- Debug read of a register in the same cycle as its write edge returns the old value before the edge and the new value after.
- Arithmetic: none inside the block; widths pass through exactly, with no truncation or extension.

Test Plan:
- Reset mid-ALU-op: accept ALU with dst=r5, assert reset during OPER -> rf[5]=0, done never pulses, instr_ready=1 after release, alu_ain/alu_bin/alu_ctrl=0.
- LOADI r1=8'hA5, LOADI r2=8'h3C -> each done 1 cycle after accept; result=A5 then 3C; rd_data@1=A5, rd_data@2=3C.
- ALU r3<=r1 op r2 with ctrl=4'h6; bench ALU stub returns ain^bin -> alu_ain=A5, alu_bin=3C, alu_ctrl=6 one edge after accept; done 2 cycles after accept; result=rf[3]=99.
- Back-to-back valid held high with 3 ALU instrs -> instr_ready low in OPER/CAPT; exactly 3 done pulses spaced 3 cycles apart; no instruction lost or duplicated.
- Aliasing: r4=8'h0F loaded; ALU r4<=r4 op r4 with stub ain+bin -> result=8'h1E; second identical op -> 8'h3C.
- NOP and kind=3 with valid=1 -> no done, no register change (all 8 rd_data unchanged), instr_ready stays 1.
